// File: rtl/sram_shared_port_arb_if.sv
// Request/grant/response bundle shared by all channels of the SRAM arbiter.
// Channel p occupies bit p, or slice p of the packed vectors.
interface sram_shared_port_arb_if #(
  parameter int NumPorts  = 2,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 32
);
  logic [NumPorts-1:0]             req_i;
  logic [NumPorts-1:0]             we_i;
  logic [NumPorts*AddrWidth-1:0]   addr_i;
  logic [NumPorts*DataWidth-1:0]   wdata_i;
  logic [NumPorts*DataWidth/8-1:0] strb_i;
  logic [NumPorts-1:0]             gnt_o;
  logic [NumPorts-1:0]             rvalid_o;
  logic                            rerr_o;
  logic [DataWidth-1:0]            rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, strb_i,
    input  gnt_o, rvalid_o, rerr_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, strb_i,
    output gnt_o, rvalid_o, rerr_o, rdata_o
  );
endinterface

// File: rtl/sram_shared_port_arb.sv
// Round-robin front-end sharing one SRAM among NumPorts channels; combinational grant,
// in-order response ReadLatency cycles after grant; a channel waits (holds req) until granted.
module sram_shared_port_arb #(
  parameter int NumPorts    = 2,
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int Depth       = 1 << 20,
  parameter int ReadLatency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(32'h8000_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_shared_port_arb_if.slave bus_if
);
  localparam int NumBytes = DataWidth / 8;
  localparam int OffBits  = $clog2(NumBytes);
  localparam int PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int MemAw    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0] DepthLim = (AddrWidth + 1)'(Depth);

  logic [PtrW-1:0]      r_rr_ptr;
  logic [PtrW:0]        w_cand;
  logic                 w_any;
  logic [PtrW-1:0]      w_sel;
  logic [PtrW-1:0]      w_next;
  logic                 w_we;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_wdata;
  logic [NumBytes-1:0]  w_strb;
  logic [AddrWidth-1:0] w_off;
  logic [AddrWidth-1:0] w_widx;
  logic [MemAw-1:0]     w_mem_idx;
  logic                 w_in_rng;
  logic                 w_wr;
  logic                 w_rd;

  logic [DataWidth-1:0]   r_mem [Depth];
  logic [ReadLatency-1:0] r_vld;
  logic [ReadLatency-1:0] r_err;
  logic [PtrW-1:0]        r_port [ReadLatency];
  logic [DataWidth-1:0]   r_dat  [ReadLatency];

  // Search starts at r_rr_ptr and wraps; first requester found wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    for (int i = 0; i < NumPorts; i++) begin
      w_cand = (PtrW + 1)'(r_rr_ptr) + (PtrW + 1)'(i);
      if (w_cand >= (PtrW + 1)'(NumPorts)) w_cand = w_cand - (PtrW + 1)'(NumPorts);
      if (!w_any && !rst_i && bus_if.req_i[w_cand[PtrW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    bus_if.gnt_o = '0;
    if (w_any) bus_if.gnt_o[w_sel] = 1'b1;
  end

  assign w_next    = (w_sel == PtrW'(NumPorts - 1)) ? '0 : w_sel + 1'b1;
  assign w_we      = bus_if.we_i[w_sel];
  assign w_addr    = bus_if.addr_i[w_sel*AddrWidth +: AddrWidth];
  assign w_wdata   = bus_if.wdata_i[w_sel*DataWidth +: DataWidth];
  assign w_strb    = bus_if.strb_i[w_sel*NumBytes +: NumBytes];
  assign w_off     = w_addr - BaseAddr;
  assign w_widx    = w_off >> OffBits;
  assign w_mem_idx = w_widx[MemAw-1:0];
  assign w_in_rng  = (w_addr >= BaseAddr) && ({1'b0, w_widx} < DepthLim);
  assign w_wr      = w_any & w_we & w_in_rng;
  assign w_rd      = w_any & ~w_we & w_in_rng;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (w_strb[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      r_err    <= '0;
      for (int s = 0; s < ReadLatency; s++) begin
        r_port[s] <= '0;
        r_dat[s]  <= '0;
      end
    end else begin
      if (w_any) r_rr_ptr <= w_next;
      r_vld[0]  <= w_any;
      r_err[0]  <= w_any & ~w_in_rng;
      r_port[0] <= w_sel;
      r_dat[0]  <= w_rd ? r_mem[w_mem_idx] : '0;
      for (int s = 1; s < ReadLatency; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_err[s]  <= r_err[s-1];
        r_port[s] <= r_port[s-1];
        r_dat[s]  <= r_dat[s-1];
      end
    end
  end

  // Outputs are masked during reset so a response due in the reset cycle is discarded too.
  always_comb begin
    bus_if.rvalid_o = '0;
    bus_if.rerr_o   = 1'b0;
    bus_if.rdata_o  = '0;
    if (r_vld[ReadLatency-1] && !rst_i) begin
      bus_if.rvalid_o[r_port[ReadLatency-1]] = 1'b1;
      bus_if.rerr_o  = r_err[ReadLatency-1];
      bus_if.rdata_o = r_dat[ReadLatency-1];
    end
  end
endmodule

// File: tb/tb_sram_shared_port_arb.sv
// Randomised + directed bench for sram_shared_port_arb (3 ports, latency 3, 16-word SRAM),
// scored against a queue/array reference model.
module tb_sram_shared_port_arb;
  localparam int NP    = 3;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    int          due;
    int          port;
    bit          err;
    logic [63:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  bit   rst = 1'b1;
  always #5 clk = ~clk;

  sram_shared_port_arb_if #(.NumPorts(NP), .DataWidth(64), .AddrWidth(32)) bus ();

  sram_shared_port_arb #(
    .NumPorts(NP), .DataWidth(64), .AddrWidth(32), .Depth(DEPTH),
    .ReadLatency(LAT), .BaseAddr(BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rr = 0;
  int          rsp_seen = 0;
  int          mark;
  logic [63:0] last_rdata;
  logic        last_rerr;
  rsp_t        exp_q[$];
  int          gnt_log[$];
  logic [63:0] mmem [DEPTH];

  bit          pend [NP];
  bit          p_we [NP];
  logic [31:0] p_addr [NP];
  logic [63:0] p_wd [NP];
  logic [7:0]  p_st [NP];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(int p, bit we, logic [31:0] a, logic [63:0] d, logic [7:0] s);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d; p_st[p] = s;
  endtask

  task automatic rand_req(int p);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = BASE - 32'(8 * $urandom_range(1, 4)) + 32'($urandom_range(0, 7));
      1:       a = BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 63));
      default: a = BASE + 32'(8 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 7));
    endcase
    set_req(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
  endtask

  task automatic apply_bus();
    for (int p = 0; p < NP; p++) begin
      bus.req_i[p]           = pend[p];
      bus.we_i[p]            = p_we[p];
      bus.addr_i[p*32 +: 32] = p_addr[p];
      bus.wdata_i[p*64 +: 64] = p_wd[p];
      bus.strb_i[p*8 +: 8]   = p_st[p];
    end
  endtask

  // One clock: check grant and response against the model, then advance the model.
  task automatic tick();
    int          g;
    int          w;
    bit          inr;
    bit          hit;
    rsp_t        r;
    logic [NP-1:0] exp_g;
    logic [NP-1:0] exp_rv;
    apply_bus();
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (g < 0 && pend[(rr + i) % NP]) g = (rr + i) % NP;
      end
    end
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    chk("gnt", 64'(bus.gnt_o), 64'(exp_g));

    hit = !rst && exp_q.size() > 0 && exp_q[0].due == cyc;
    r = '{due: 0, port: 0, err: 1'b0, dat: 64'h0};
    if (hit) r = exp_q.pop_front();
    exp_rv = '0;
    if (hit) exp_rv[r.port] = 1'b1;
    chk("rvalid", 64'(bus.rvalid_o), 64'(exp_rv));
    chk("rerr", 64'(bus.rerr_o), 64'(hit ? r.err : 1'b0));
    chk("rdata", bus.rdata_o, hit ? r.dat : 64'h0);
    if (bus.rvalid_o != '0) begin
      rsp_seen++;
      last_rdata = bus.rdata_o;
      last_rerr  = bus.rerr_o;
    end

    if (rst) begin
      exp_q.delete();
      rr = 0;
    end else if (g >= 0) begin
      inr = 1'b0;
      w   = 0;
      if (p_addr[g] >= BASE) begin
        w   = int'((p_addr[g] - BASE) / 8);
        inr = (w < DEPTH);
      end
      r.due  = cyc + LAT;
      r.port = g;
      r.err  = !inr;
      r.dat  = (!p_we[g] && inr) ? mmem[w] : 64'h0;
      exp_q.push_back(r);
      if (p_we[g] && inr) begin
        for (int b = 0; b < 8; b++)
          if (p_st[g][b]) mmem[w][b*8 +: 8] = p_wd[g][b*8 +: 8];
      end
      rr = (g + 1) % NP;
      gnt_log.push_back(g);
      pend[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    clear_reqs();
    for (int i = 0; i < LAT + 2; i++) tick();
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = BASE; p_wd[p] = 64'h0; p_st[p] = 8'h0;
    end

    // Reset: a pending request must not be granted.
    rst = 1'b1;
    set_req(0, 1'b1, BASE, 64'h1, 8'hFF);
    repeat (3) tick();
    clear_reqs();
    rst = 1'b0;

    // Round-robin with all three ports requesting writes.
    gnt_log.delete();
    mark = 0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p]) begin
          set_req(p, 1'b1, BASE + 32'(8 * (mark % DEPTH)), {$urandom, $urandom}, 8'hFF);
          mark++;
        end
      tick();
    end
    clear_reqs();
    for (int k = 0; k < 6; k++) chk("rr_seq", 64'(gnt_log[k]), 64'(k % NP));
    gnt_log.delete();
    set_req(0, 1'b1, BASE, 64'h5, 8'hFF);
    tick();
    set_req(2, 1'b1, BASE + 32'h8, 64'h6, 8'hFF);
    tick();
    chk("rr_p0", 64'(gnt_log[0]), 64'd0);
    chk("rr_p2", 64'(gnt_log[1]), 64'd2);

    // Fill every word so later reads have defined data.
    for (int w = 0; w < DEPTH; w++) begin
      set_req(0, 1'b1, BASE + 32'(8 * w), {$urandom, $urandom}, 8'hFF);
      tick();
    end

    // Write then read back-to-back.
    set_req(0, 1'b1, 32'h8000_0008, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    tick();
    set_req(0, 1'b0, 32'h8000_0008, 64'h0, 8'h00);
    tick();
    drain();
    chk("raw_rd", last_rdata, 64'hDEAD_BEEF_0123_4567);

    // Byte strobes.
    set_req(1, 1'b1, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    set_req(1, 1'b1, 32'h8000_0010, 64'h0, 8'h0F);
    tick();
    set_req(1, 1'b0, 32'h8000_0010, 64'h0, 8'h00);
    tick();
    drain();
    chk("strb_rd", last_rdata, 64'hFFFF_FFFF_0000_0000);

    // Four back-to-back reads alternating ports 0 and 1.
    mark = rsp_seen;
    for (int k = 0; k < 4; k++) begin
      set_req(k % 2, 1'b0, BASE + 32'(8 * (3 + k)), 64'h0, 8'h00);
      tick();
    end
    drain();
    chk("lat_cnt", 64'(rsp_seen - mark), 64'd4);

    // Out-of-window read and write.
    set_req(1, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00);
    tick();
    drain();
    chk("oor_rerr", 64'(last_rerr), 64'd1);
    chk("oor_rdata", last_rdata, 64'h0);
    set_req(0, 1'b1, BASE, 64'h0123_4567_89AB_CDEF, 8'hFF);
    tick();
    set_req(0, 1'b1, BASE + 32'(DEPTH * 8), 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    tick();
    drain();
    chk("oor_wr_err", 64'(last_rerr), 64'd1);
    set_req(0, 1'b0, BASE, 64'h0, 8'h00);
    tick();
    drain();
    chk("oor_w0", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Reset two cycles after a read grant discards the response.
    set_req(1, 1'b0, BASE, 64'h0, 8'h00);
    mark = rsp_seen;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("rst_norsp", 64'(rsp_seen - mark), 64'd0);
    gnt_log.delete();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, BASE, 64'h0, 8'h00);
    tick();
    clear_reqs();
    chk("rst_rr", 64'(gnt_log[0]), 64'd0);
    drain();
    chk("rst_keep", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) rand_req(p);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drain();
    chk("q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
